// File: rtl/counter_pkg.sv
// Shared types and mode encodings for the up/down counter family.
package counter_pkg;

    // Counting behaviour at the terminal value; encoding 2'b11 is decoded as wrap.
    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10
    } cnt_mode_t;

    // A one-shot run parks in HALT until load or reset.
    typedef enum logic {
        CNT_RUN  = 1'b0,
        CNT_HALT = 1'b1
    } cnt_state_t;

    // Raw encodings of the 2-bit mode port.
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

endpackage

// File: rtl/definitions_pkg.sv
// Lab-wide definitions; pulls the counter types into the common namespace.
package definitions_pkg;

    import counter_pkg::*;

    localparam int CNT_DEFAULT_WIDTH = 4;

    typedef cnt_mode_t  lab_cnt_mode_t;
    typedef cnt_state_t lab_cnt_state_t;

endpackage

// File: rtl/cnt_if.sv
// Shared counter interface, carrying the control inputs and status outputs.
interface cnt_if #(
    parameter int WIDTH = 4
);
    logic             rstn;
    logic             en;
    logic             load_en;
    logic [WIDTH-1:0] load;
    logic             down;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             rollover;
    logic             at_max;
    logic             at_min;
    logic             done;

    modport ctrl (
        output rstn, en, load_en, load, down, mode,
        input  count, rollover, at_max, at_min, done
    );

    modport cnt (
        input  rstn, en, load_en, load, down, mode,
        output count, rollover, at_max, at_min, done
    );
endinterface

// File: rtl/cnt_next_val.sv
// Combinational next-count logic: step, terminal detection and wrap decision.
module cnt_next_val
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 2**WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic             down,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap,
    output logic             terminal
);

    // One extra bit so MOD == 2**WIDTH is representable and underflow is visible.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;
    logic           term_up;
    logic           term_dn;

    assign cnt_x   = {1'b0, count};
    assign inc     = cnt_x + 1'b1;
    assign dec     = cnt_x - 1'b1;
    assign term_up = (inc == MOD_W);
    assign term_dn = dec[WIDTH];

    // Plain step away from the terminal; mode decides what happens at it.
    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        terminal   = down ? term_dn : term_up;
        if (!terminal) begin
            next_count = down ? dec[WIDTH-1:0] : inc[WIDTH-1:0];
        end else begin
            case (mode)
                MODE_SAT, MODE_ONESHOT: next_count = count;
                default: begin
                    next_count = down ? MAX_V : '0;
                    wrap       = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_ud_mod.sv
// Parametrised up/down counter with modulus, enable, wrap/sat/one-shot modes
// and terminal flags. Holds the count registers and the RUN/HALT FSM.
module counter_ud_mod
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load,
    input  logic             down,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             rollover,
    output logic             at_max,
    output logic             at_min,
    output logic             done
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    cnt_state_t       state;
    logic [WIDTH-1:0] next_count;
    logic             wrap;
    logic             terminal;
    logic [WIDTH-1:0] load_clamped;
    logic             is_oneshot;

    cnt_next_val #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next (
        .count      (count),
        .down       (down),
        .mode       (mode),
        .next_count (next_count),
        .wrap       (wrap),
        .terminal   (terminal)
    );

    // Out-of-range load values pin to the top of the legal range.
    assign load_clamped = ({1'b0, load} >= MOD_W) ? MAX_V : load;
    assign is_oneshot   = (mode == MODE_ONESHOT);

    assign at_max = (count == MAX_V);
    assign at_min = (count == '0);

    // Priority: reset > load > enabled step in RUN > hold; rollover is a one-edge pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count    <= '0;
            rollover <= 1'b0;
            done     <= 1'b0;
            state    <= CNT_RUN;
        end else if (load_en) begin
            count    <= load_clamped;
            rollover <= 1'b0;
            done     <= 1'b0;
            state    <= CNT_RUN;
        end else if (en && state == CNT_RUN) begin
            count    <= next_count;
            rollover <= wrap;
            if (terminal && is_oneshot) begin
                done  <= 1'b1;
                state <= CNT_HALT;
            end
        end else begin
            rollover <= 1'b0;
        end
    end

endmodule
